// File: rtl/risc_mmu_pkg.sv
// Shared MMU definitions for the RiSC TLB-miss walker.
//   - PTE field positions (valid bit, PFN field)
//   - Walker FSM state encoding
//   - Default widths for VPN, PFN, ASID and TLB depth
//   - Helper that forms the PTE address from the table base and the VPN
package risc_mmu_pkg;

  localparam int ADDR_W          = 16;
  localparam int PTE_V_BIT       = 15;
  localparam int DEF_NUM_ENTRIES = 8;
  localparam int DEF_VPN_W       = 8;
  localparam int DEF_PFN_W       = 8;
  localparam int DEF_ASID_W      = 6;
  localparam int PTE_PFN_LSB     = 0;
  localparam int PTE_PFN_MSB     = PTE_PFN_LSB + DEF_PFN_W - 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_CHECK = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4,
    S_FAULT = 3'd5
  } walk_state_t;

  // PTE address: base + zero-extended VPN, wrapping modulo 2^16.
  function automatic logic [ADDR_W-1:0] pte_addr(input logic [ADDR_W-1:0] base,
                                                 input logic [ADDR_W-1:0] vpn_ext);
    return base + vpn_ext;
  endfunction

endpackage

// File: rtl/rr_victim_ptr.sv
// Round-robin victim pointer for the TLB.
//   clk, reset : clock, synchronous active-high reset (pointer -> 0)
//   adv_i      : advance by one entry, wrapping at NUM_ENTRIES
//   ptr_o      : current victim index
module rr_victim_ptr #(
  parameter int NUM_ENTRIES = 8
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           adv_i,
  output logic [$clog2(NUM_ENTRIES)-1:0] ptr_o
);

  localparam int IDX_W = $clog2(NUM_ENTRIES);

  logic [IDX_W-1:0] ptr_q;
  logic [IDX_W-1:0] ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (adv_i) begin
      ptr_d = (ptr_q == IDX_W'(NUM_ENTRIES - 1)) ? '0 : ptr_q + IDX_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/tlb_refill_ctrl.sv
// TLB-miss walker: on a pipeline miss, reads one PTE over the MEM req/ack
// port and either writes a {asid, vpn, pfn} entry into the TLB at the
// round-robin victim index or reports a page fault.
//
// Ports
//   clk, reset       : clock, synchronous active-high reset
//   miss_req         : level miss request, held until done/fault pulse
//   miss_vpn/asid    : miss context, captured when the request is accepted
//   ptbr             : page-table base register
//   mem_req/mem_addr : PTE read request and address (stable until mem_ack)
//   mem_rdata/ack    : PTE data, valid with the one-cycle acknowledge
//   tlb_we, tlb_idx  : one-cycle TLB write strobe and victim index
//   tlb_vpn/asid/pfn : entry contents (latched values)
//   busy             : walker not idle
//   miss_done        : one-cycle pulse, refill written
//   miss_fault       : one-cycle pulse, PTE invalid
//   dbg_state        : current walker state
//
// Handshake: mem_req rises the cycle after acceptance and stays high with a
// constant mem_addr until the cycle mem_ack=1; mem_ack in any other state is
// ignored. miss_req is sampled only in IDLE.
module tlb_refill_ctrl
  import risc_mmu_pkg::*;
#(
  parameter int NUM_ENTRIES = DEF_NUM_ENTRIES,
  parameter int VPN_W       = DEF_VPN_W,
  parameter int PFN_W       = DEF_PFN_W,
  parameter int ASID_W      = DEF_ASID_W
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           miss_req,
  input  logic [VPN_W-1:0]               miss_vpn,
  input  logic [ASID_W-1:0]              miss_asid,
  input  logic [15:0]                    ptbr,
  output logic                           mem_req,
  output logic [15:0]                    mem_addr,
  input  logic [15:0]                    mem_rdata,
  input  logic                           mem_ack,
  output logic                           tlb_we,
  output logic [$clog2(NUM_ENTRIES)-1:0] tlb_idx,
  output logic [VPN_W-1:0]               tlb_vpn,
  output logic [ASID_W-1:0]              tlb_asid,
  output logic [PFN_W-1:0]               tlb_pfn,
  output logic                           busy,
  output logic                           miss_done,
  output logic                           miss_fault,
  output walk_state_t                    dbg_state
);

  walk_state_t        state_q;
  logic [VPN_W-1:0]   vpn_q;
  logic [ASID_W-1:0]  asid_q;
  logic [PFN_W-1:0]   pfn_q;
  logic               pte_v_q;
  logic [15:0]        mem_addr_q;
  logic               mem_req_q;
  logic               tlb_we_q;
  logic               done_q;
  logic               fault_q;

  // Only the valid bit and PFN field of the PTE are used.
  logic unused_rdata;
  assign unused_rdata = ^mem_rdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      vpn_q      <= '0;
      asid_q     <= '0;
      pfn_q      <= '0;
      pte_v_q    <= 1'b0;
      mem_addr_q <= '0;
      mem_req_q  <= 1'b0;
      tlb_we_q   <= 1'b0;
      done_q     <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      // Strobes are single-cycle unless re-asserted below.
      tlb_we_q <= 1'b0;
      done_q   <= 1'b0;
      fault_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (miss_req) begin
            vpn_q      <= miss_vpn;
            asid_q     <= miss_asid;
            // Address is captured once so it cannot move while waiting for ack.
            mem_addr_q <= pte_addr(ptbr, 16'(miss_vpn));
            mem_req_q  <= 1'b1;
            state_q    <= S_READ;
          end
        end
        S_READ: begin
          if (mem_ack) begin
            pte_v_q   <= mem_rdata[PTE_V_BIT];
            pfn_q     <= mem_rdata[PTE_PFN_LSB +: PFN_W];
            mem_req_q <= 1'b0;
            state_q   <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (pte_v_q) begin
            tlb_we_q <= 1'b1;
            state_q  <= S_WRITE;
          end else begin
            fault_q <= 1'b1;
            state_q <= S_FAULT;
          end
        end
        S_WRITE: begin
          done_q  <= 1'b1;
          state_q <= S_DONE;
        end
        S_DONE:  state_q <= S_IDLE;
        S_FAULT: state_q <= S_IDLE;
        default: begin
          mem_req_q <= 1'b0;
          state_q   <= S_IDLE;
        end
      endcase
    end
  end

  // The victim advances at the end of the WRITE cycle, after its index was used.
  rr_victim_ptr #(
    .NUM_ENTRIES(NUM_ENTRIES)
  ) u_victim (
    .clk  (clk),
    .reset(reset),
    .adv_i(state_q == S_WRITE),
    .ptr_o(tlb_idx)
  );

  assign mem_req    = mem_req_q;
  assign mem_addr   = mem_addr_q;
  assign tlb_we     = tlb_we_q;
  assign tlb_vpn    = vpn_q;
  assign tlb_asid   = asid_q;
  assign tlb_pfn    = pfn_q;
  assign busy       = (state_q != S_IDLE);
  assign miss_done  = done_q;
  assign miss_fault = fault_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_tlb_refill_ctrl.sv
// Bench for tlb_refill_ctrl (default parameters: 8 entries, 8/8/6-bit fields).
module tb_tlb_refill_ctrl;
  import risc_mmu_pkg::*;

  localparam int ENT_W = 3 + 6 + 8 + 8;  // {idx, asid, vpn, pfn}

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        miss_req;
  logic [7:0]  miss_vpn;
  logic [5:0]  miss_asid;
  logic [15:0] ptbr;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic [15:0] mem_rdata;
  logic        mem_ack;
  logic        tlb_we;
  logic [2:0]  tlb_idx;
  logic [7:0]  tlb_vpn;
  logic [5:0]  tlb_asid;
  logic [7:0]  tlb_pfn;
  logic        busy;
  logic        miss_done;
  logic        miss_fault;
  walk_state_t dbg_state;

  tlb_refill_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .miss_req  (miss_req),
    .miss_vpn  (miss_vpn),
    .miss_asid (miss_asid),
    .ptbr      (ptbr),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack),
    .tlb_we    (tlb_we),
    .tlb_idx   (tlb_idx),
    .tlb_vpn   (tlb_vpn),
    .tlb_asid  (tlb_asid),
    .tlb_pfn   (tlb_pfn),
    .busy      (busy),
    .miss_done (miss_done),
    .miss_fault(miss_fault),
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard ----------------
  logic [ENT_W-1:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;
  int model_ptr = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset     = 1'b1;
    miss_req  = 1'b0;
    mem_ack   = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // One complete walk. Cycle t counts from the acceptance cycle (t=0).
  task automatic do_walk(input logic [7:0] vpn, input logic [5:0] asid,
                         input logic [15:0] base, input logic [15:0] pte, input int dly,
                         input logic [15:0] exp_addr, input logic exp_ok,
                         input logic [2:0] exp_idx, input string tag);
    int t;
    bit seen_we, seen_done, seen_fault;
    logic [ENT_W-1:0] got, exp_ent;
    seen_we = 0; seen_done = 0; seen_fault = 0;
    if (exp_ok) exp_q.push_back({exp_idx, asid, vpn, pte[7:0]});
    ptbr      = base;
    miss_vpn  = vpn;
    miss_asid = asid;
    miss_req  = 1'b1;
    check({tag, "_idle_busy"}, 32'(busy), 0);
    tick();
    t = 1;
    // Context changes after acceptance must not reach the TLB entry.
    miss_vpn  = 8'($urandom);
    miss_asid = 6'($urandom);
    for (int i = 0; i <= dly; i++) begin
      check({tag, "_mem_req"}, 32'(mem_req), 1);
      check({tag, "_mem_addr"}, 32'(mem_addr), 32'(exp_addr));
      check({tag, "_busy_read"}, 32'(busy), 1);
      if (i == dly) begin
        mem_ack   = 1'b1;
        mem_rdata = pte;
      end else begin
        mem_rdata = 16'($urandom);
      end
      tick();
      t++;
      mem_ack   = 1'b0;
      mem_rdata = 16'($urandom);
    end
    check({tag, "_mem_req_drop"}, 32'(mem_req), 0);
    while (!(seen_done || seen_fault) && t < 12 + dly) begin
      if (tlb_we) begin
        seen_we = 1;
        check({tag, "_we_time"}, 32'(t), 32'(3 + dly));
        got = {tlb_idx, tlb_asid, tlb_vpn, tlb_pfn};
        if (exp_q.size() > 0) begin
          exp_ent = exp_q.pop_front();
          check({tag, "_entry"}, 32'(got), 32'(exp_ent));
        end else begin
          check({tag, "_we_unexpected"}, 32'(tlb_we), 0);
        end
      end
      if (miss_done) begin
        seen_done = 1;
        check({tag, "_done_time"}, 32'(t), 32'(4 + dly));
        miss_req = 1'b0;
      end
      if (miss_fault) begin
        seen_fault = 1;
        check({tag, "_fault_time"}, 32'(t), 32'(3 + dly));
        miss_req = 1'b0;
      end
      check({tag, "_busy_walk"}, 32'(busy), 1);
      // Stray acknowledges outside READ must be ignored.
      mem_ack   = 1'($urandom_range(0, 1));
      mem_rdata = 16'($urandom);
      tick();
      t++;
    end
    mem_ack  = 1'b0;
    miss_req = 1'b0;
    check({tag, "_seen_we"}, 32'(seen_we), 32'(exp_ok));
    check({tag, "_seen_done"}, 32'(seen_done), 32'(exp_ok));
    check({tag, "_seen_fault"}, 32'(seen_fault), 32'(!exp_ok));
    check({tag, "_busy_end"}, 32'(busy), 0);
    check({tag, "_mem_req_end"}, 32'(mem_req), 0);
    if (!exp_ok) void'(exp_q.size());
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    logic [15:0] base;
    logic [7:0]  vpn;
    logic [5:0]  asid;
    logic [15:0] pte;
    int          dly;
    logic [15:0] exp_addr;
    logic        exp_ok;
    logic [2:0]  exp_idx;
  } vec_t;

  vec_t tbl[6];

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [7:0]  r_vpn;
    logic [5:0]  r_asid;
    logic [15:0] r_base, r_pte, r_addr;
    logic        r_ok;
    int          r_dly;

    miss_vpn = '0; miss_asid = '0; ptbr = '0; mem_rdata = '0;
    apply_reset();

    // Reset state
    check("rst_busy", 32'(busy), 0);
    check("rst_mem_req", 32'(mem_req), 0);
    check("rst_mem_addr", 32'(mem_addr), 0);
    check("rst_tlb_we", 32'(tlb_we), 0);
    check("rst_idx", 32'(tlb_idx), 0);
    check("rst_entry", 32'({tlb_asid, tlb_vpn, tlb_pfn}), 0);
    check("rst_pulses", 32'({miss_done, miss_fault}), 0);
    check("rst_state", 32'(dbg_state), 32'(S_IDLE));

    //          base      vpn    asid   pte       dly addr      ok    idx
    tbl[0] = '{16'h0100, 8'hC9, 6'h00, 16'h8002, 0, 16'h01C9, 1'b1, 3'd0};  // basic refill
    tbl[1] = '{16'h0100, 8'hC9, 6'h00, 16'h0002, 0, 16'h01C9, 1'b0, 3'd0};  // fault
    tbl[2] = '{16'h0100, 8'hC9, 6'h03, 16'h8055, 5, 16'h01C9, 1'b1, 3'd1};  // slow memory
    tbl[3] = '{16'hFFF0, 8'h20, 6'h2A, 16'h8011, 1, 16'h0010, 1'b1, 3'd2};  // address wrap
    tbl[4] = '{16'hFFFF, 8'h01, 6'h15, 16'hFFFF, 2, 16'h0000, 1'b1, 3'd3};  // wrap to zero
    tbl[5] = '{16'h0000, 8'hFF, 6'h3F, 16'h7FFF, 3, 16'h00FF, 1'b0, 3'd0};  // fault, junk bits
    for (int i = 0; i < 6; i++) begin
      do_walk(tbl[i].vpn, tbl[i].asid, tbl[i].base, tbl[i].pte, tbl[i].dly,
              tbl[i].exp_addr, tbl[i].exp_ok, tbl[i].exp_idx, $sformatf("tbl%0d", i));
    end

    // Round-robin: nine refills from reset -> idx 0..7 then 0.
    apply_reset();
    for (int i = 0; i < 9; i++) begin
      do_walk(8'(i * 17), 6'(i), 16'h2000, 16'h8000 | 16'(i + 1), i % 3,
              16'h2000 + 16'(i * 17), 1'b1, 3'(i % 8), $sformatf("rr%0d", i));
    end

    // Reset in the middle of READ.
    ptbr = 16'h0400; miss_vpn = 8'h12; miss_asid = 6'h05; miss_req = 1'b1;
    tick();
    tick();
    check("midrst_mem_req_before", 32'(mem_req), 1);
    reset    = 1'b1;
    miss_req = 1'b0;
    tick();
    check("midrst_mem_req", 32'(mem_req), 0);
    check("midrst_busy", 32'(busy), 0);
    check("midrst_state", 32'(dbg_state), 32'(S_IDLE));
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("midrst_no_pulse", 32'({tlb_we, miss_done, miss_fault}), 0);
      tick();
    end
    do_walk(8'h12, 6'h05, 16'h0400, 16'h80AB, 1, 16'h0412, 1'b1, 3'd0, "midrst_next");

    // Randomised walks against the reference model.
    model_ptr = 1;
    for (int i = 0; i < 30; i++) begin
      r_vpn  = 8'($urandom_range(0, 255));
      r_asid = 6'($urandom_range(0, 63));
      r_base = ($urandom_range(0, 3) == 0) ? 16'hFF00 + 16'($urandom_range(0, 255))
                                           : 16'($urandom);
      r_pte  = 16'($urandom);
      r_dly  = $urandom_range(0, 4);
      r_addr = 16'((int'(r_base) + int'(r_vpn)) % 65536);
      r_ok   = (int'(r_pte) >= 32768);
      do_walk(r_vpn, r_asid, r_base, r_pte, r_dly, r_addr, r_ok, 3'(model_ptr % 8),
              $sformatf("rnd%0d", i));
      if (r_ok) model_ptr = (model_ptr + 1) % 8;
    end

    check("exp_q_drained", 32'(exp_q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
